// File: rtl/header_parse_engine.sv
// Ethernet/VLAN header parser on a byte-keep stream (AXI-Stream monitor).
// Ports: clk/rst; s_t* monitored beat; hdr_valid/hdr_err pulses, busy; parsed fields + raw hdr_bytes.
module header_parse_engine #(
  parameter int DATA_WIDTH = 64,
  parameter int VLAN_DEPTH = 2,
  localparam int MAX_HDR = 14 + 4 * VLAN_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  input  logic                     s_tready,
  input  logic                     s_tlast,
  input  logic [DATA_WIDTH-1:0]    s_tdata,
  input  logic [DATA_WIDTH/8-1:0]  s_tkeep,
  output logic                     hdr_valid,
  output logic                     hdr_err,
  output logic                     busy,
  output logic [47:0]              dst_mac,
  output logic [47:0]              src_mac,
  output logic [15:0]              ethertype,
  output logic [1:0]               vlan_count,
  output logic [15:0]              outer_tci,
  output logic [15:0]              inner_tci,
  output logic [4:0]               hdr_len,
  output logic [MAX_HDR-1:0][7:0]  hdr_bytes
);

  localparam int NB = DATA_WIDTH / 8;
  // Buffer is sized for two tags regardless of VLAN_DEPTH so that the
  // fixed TCI byte offsets below are always in range.
  localparam int BUF_N = 22;
  localparam logic [1:0] MAXTAGS = 2'(VLAN_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_SKIP    = 2'd2;

  logic [1:0]             r_state;
  logic [4:0]             r_cnt;
  logic [4:0]             r_req;
  logic [1:0]             r_tags;
  logic [BUF_N-1:0][7:0]  r_buf;

  logic                   r_hdr_valid;
  logic                   r_hdr_err;
  logic [47:0]            r_dst_mac;
  logic [47:0]            r_src_mac;
  logic [15:0]            r_ethertype;
  logic [1:0]             r_vlan_count;
  logic [15:0]            r_outer_tci;
  logic [15:0]            r_inner_tci;
  logic [4:0]             r_hdr_len;
  logic [MAX_HDR-1:0][7:0] r_hdr_bytes;

  logic                   w_fire;
  logic [4:0]             w_cnt;
  logic [4:0]             w_req;
  logic [1:0]             w_tags;
  logic [BUF_N-1:0][7:0]  w_buf;
  logic                   w_done;
  logic                   w_keep_ok;
  logic [15:0]            w_tpid;

  assign w_fire = s_tvalid && s_tready;

  // Walk every byte of the beat in order. A frame start uses fresh
  // counter/length values; TPID checks and completion happen byte by
  // byte, so several tags can resolve inside one wide beat.
  always_comb begin
    w_cnt     = (r_state == S_IDLE) ? 5'd0  : r_cnt;
    w_req     = (r_state == S_IDLE) ? 5'd14 : r_req;
    w_tags    = (r_state == S_IDLE) ? 2'd0  : r_tags;
    w_buf     = r_buf;
    w_done    = 1'b0;
    w_keep_ok = 1'b1;
    w_tpid    = 16'h0000;
    for (int i = 0; i < NB; i++) begin
      w_keep_ok = w_keep_ok & s_tkeep[i];
      if (w_keep_ok && !w_done) begin
        w_buf[w_cnt] = s_tdata[8*i +: 8];
        w_cnt = w_cnt + 5'd1;
        w_tpid = {w_buf[w_cnt - 5'd2], w_buf[w_cnt - 5'd1]};
        if ((w_tags < MAXTAGS) &&
            (w_cnt == 5'd14 + {1'b0, w_tags, 2'b00}) &&
            ((w_tpid == 16'h8100) || (w_tpid == 16'h88A8))) begin
          w_tags = w_tags + 2'd1;
          w_req  = w_req + 5'd4;
        end
        if (w_cnt == w_req) begin
          w_done = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_tags       <= '0;
      r_buf        <= '0;
      r_hdr_valid  <= 1'b0;
      r_hdr_err    <= 1'b0;
      r_dst_mac    <= '0;
      r_src_mac    <= '0;
      r_ethertype  <= '0;
      r_vlan_count <= '0;
      r_outer_tci  <= '0;
      r_inner_tci  <= '0;
      r_hdr_len    <= '0;
      r_hdr_bytes  <= '0;
    end else begin
      r_hdr_valid <= 1'b0;
      r_hdr_err   <= 1'b0;
      if (w_fire) begin
        case (r_state)
          S_IDLE, S_CAPTURE: begin
            if (w_done) begin
              r_hdr_valid  <= 1'b1;
              r_state      <= s_tlast ? S_IDLE : S_SKIP;
              r_dst_mac    <= {w_buf[0], w_buf[1], w_buf[2],
                               w_buf[3], w_buf[4], w_buf[5]};
              r_src_mac    <= {w_buf[6], w_buf[7], w_buf[8],
                               w_buf[9], w_buf[10], w_buf[11]};
              r_ethertype  <= {w_buf[w_cnt - 5'd2], w_buf[w_cnt - 5'd1]};
              r_vlan_count <= w_tags;
              r_outer_tci  <= (w_tags != 2'd0) ?
                              {w_buf[14], w_buf[15]} : 16'h0000;
              r_inner_tci  <= (w_tags == 2'd2) ?
                              {w_buf[18], w_buf[19]} : 16'h0000;
              r_hdr_len    <= w_cnt;
              for (int j = 0; j < MAX_HDR; j++) begin
                r_hdr_bytes[j] <= (5'(j) < w_cnt) ? w_buf[j] : 8'h00;
              end
            end else if (s_tlast) begin
              r_hdr_err <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_CAPTURE;
              r_cnt   <= w_cnt;
              r_req   <= w_req;
              r_tags  <= w_tags;
              r_buf   <= w_buf;
            end
          end
          S_SKIP: begin
            if (s_tlast) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign hdr_valid  = r_hdr_valid;
  assign hdr_err    = r_hdr_err;
  assign busy       = (r_state != S_IDLE);
  assign dst_mac    = r_dst_mac;
  assign src_mac    = r_src_mac;
  assign ethertype  = r_ethertype;
  assign vlan_count = r_vlan_count;
  assign outer_tci  = r_outer_tci;
  assign inner_tci  = r_inner_tci;
  assign hdr_len    = r_hdr_len;
  assign hdr_bytes  = r_hdr_bytes;

endmodule

// File: tb/tb_header_parse_engine.sv
// Randomized bench for header_parse_engine: four parameterizations
// checked every cycle against a frame-level byte-queue model.
module tb_header_parse_engine;
  localparam int ND = 4;

  typedef struct packed {
    logic [47:0]      dst;
    logic [47:0]      src;
    logic [15:0]      eth;
    logic [15:0]      ot;
    logic [15:0]      it;
    logic [1:0]       vc;
    logic [4:0]       len;
    logic [21:0][7:0] hb;
  } fld_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, s_valid, s_tready, s_tlast;
  logic [255:0] s_tdata;
  logic [31:0] s_tkeep;
  int sel;
  logic [ND-1:0] tv;
  logic [ND-1:0] o_v, o_e, o_b;
  logic [47:0] o_dst[ND];
  logic [47:0] o_src[ND];
  logic [15:0] o_eth[ND];
  logic [15:0] o_ot[ND];
  logic [15:0] o_it[ND];
  logic [1:0] o_vc[ND];
  logic [4:0] o_len[ND];
  logic [21:0][7:0] hb0, hb1, hb2;
  logic [17:0][7:0] hb3;

  always_comb begin
    tv = '0;
    for (int d = 0; d < ND; d++) tv[d] = s_valid && (sel == d);
  end

  header_parse_engine #(.DATA_WIDTH(64), .VLAN_DEPTH(2)) u0 (
    .clk(clk), .rst(rst), .s_tvalid(tv[0]), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tdata(s_tdata[63:0]), .s_tkeep(s_tkeep[7:0]),
    .hdr_valid(o_v[0]), .hdr_err(o_e[0]), .busy(o_b[0]),
    .dst_mac(o_dst[0]), .src_mac(o_src[0]), .ethertype(o_eth[0]),
    .vlan_count(o_vc[0]), .outer_tci(o_ot[0]), .inner_tci(o_it[0]),
    .hdr_len(o_len[0]), .hdr_bytes(hb0));

  header_parse_engine #(.DATA_WIDTH(8), .VLAN_DEPTH(2)) u1 (
    .clk(clk), .rst(rst), .s_tvalid(tv[1]), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tdata(s_tdata[7:0]), .s_tkeep(s_tkeep[0:0]),
    .hdr_valid(o_v[1]), .hdr_err(o_e[1]), .busy(o_b[1]),
    .dst_mac(o_dst[1]), .src_mac(o_src[1]), .ethertype(o_eth[1]),
    .vlan_count(o_vc[1]), .outer_tci(o_ot[1]), .inner_tci(o_it[1]),
    .hdr_len(o_len[1]), .hdr_bytes(hb1));

  header_parse_engine #(.DATA_WIDTH(256), .VLAN_DEPTH(2)) u2 (
    .clk(clk), .rst(rst), .s_tvalid(tv[2]), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .hdr_valid(o_v[2]), .hdr_err(o_e[2]), .busy(o_b[2]),
    .dst_mac(o_dst[2]), .src_mac(o_src[2]), .ethertype(o_eth[2]),
    .vlan_count(o_vc[2]), .outer_tci(o_ot[2]), .inner_tci(o_it[2]),
    .hdr_len(o_len[2]), .hdr_bytes(hb2));

  header_parse_engine #(.DATA_WIDTH(64), .VLAN_DEPTH(1)) u3 (
    .clk(clk), .rst(rst), .s_tvalid(tv[3]), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tdata(s_tdata[63:0]), .s_tkeep(s_tkeep[7:0]),
    .hdr_valid(o_v[3]), .hdr_err(o_e[3]), .busy(o_b[3]),
    .dst_mac(o_dst[3]), .src_mac(o_src[3]), .ethertype(o_eth[3]),
    .vlan_count(o_vc[3]), .outer_tci(o_ot[3]), .inner_tci(o_it[3]),
    .hdr_len(o_len[3]), .hdr_bytes(hb3));

  fld_t ef[ND];
  fld_t nf[ND];
  logic [2:0] es[ND];
  logic [2:0] ns[ND];
  int mode[ND];
  int vcnt[ND];
  int ecnt[ND];
  int vcyc[ND];
  logic [7:0] q[$];
  logic [7:0] bb[32];
  logic [7:0] fb[128];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  fld_t ca;

  function automatic int nb_of(int d);
    case (d)
      1: return 1;
      2: return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int dep_of(int d);
    return (d == 3) ? 1 : 2;
  endfunction

  function automatic logic [175:0] hb_of(int d);
    case (d)
      0: return hb0;
      1: return hb1;
      2: return hb2;
      default: return {32'h0, hb3};
    endcase
  endfunction

  task automatic cmpw(string nm, int d, logic [511:0] a, logic [511:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s dut%0d got=%0h want=%0h", nm, d, a, e);
    end
  endtask

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        ca.dst = o_dst[d];
        ca.src = o_src[d];
        ca.eth = o_eth[d];
        ca.ot  = o_ot[d];
        ca.it  = o_it[d];
        ca.vc  = o_vc[d];
        ca.len = o_len[d];
        ca.hb  = hb_of(d);
        cmpw("pulse/busy", d, {o_v[d], o_e[d], o_b[d]}, es[d]);
        cmpw("fields", d, ca, ef[d]);
        if (o_v[d]) begin
          vcnt[d]++;
          vcyc[d] = cyc;
        end
        if (o_e[d]) ecnt[d]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      es[d] = ns[d];
      ef[d] = nf[d];
      ns[d][2:1] = 2'b00;
    end
    cyc++;
  endtask

  // Header length implied by the bytes collected so far.
  function automatic int req_len(int depth);
    int l;
    l = 14;
    for (int k = 0; k < depth; k++) begin
      if (q.size() < 14 + 4 * k) break;
      if (!({q[12+4*k], q[13+4*k]} == 16'h8100 ||
            {q[12+4*k], q[13+4*k]} == 16'h88A8)) break;
      l += 4;
    end
    return l;
  endfunction

  task automatic model_beat(int d, int n, logic last);
    bit done;
    int l;
    if (mode[d] == 2) begin
      if (last) mode[d] = 0;
      ns[d][0] = (mode[d] != 0);
      return;
    end
    if (mode[d] == 0) begin
      q.delete();
      mode[d] = 1;
    end
    done = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!done) begin
        q.push_back(bb[i]);
        if (q.size() == req_len(dep_of(d))) done = 1'b1;
      end
    end
    if (done) begin
      l = q.size();
      nf[d] = '0;
      nf[d].len = 5'(l);
      nf[d].vc = 2'((l - 14) / 4);
      nf[d].dst = {q[0], q[1], q[2], q[3], q[4], q[5]};
      nf[d].src = {q[6], q[7], q[8], q[9], q[10], q[11]};
      nf[d].eth = {q[l-2], q[l-1]};
      if (l >= 18) nf[d].ot = {q[14], q[15]};
      if (l >= 22) nf[d].it = {q[18], q[19]};
      for (int j = 0; j < l; j++) nf[d].hb[j] = q[j];
      ns[d][2] = 1'b1;
      mode[d] = last ? 0 : 2;
    end else if (last) begin
      ns[d][1] = 1'b1;
      mode[d] = 0;
    end
    ns[d][0] = (mode[d] != 0);
  endtask

  task automatic idle_cycle();
    int r;
    r = $urandom_range(0, 1);
    s_valid = r[0];
    s_tready = r[0] ? 1'b0 : 1'($urandom_range(0, 1));
    s_tlast = 1'($urandom_range(0, 1));
    s_tdata = {8{$urandom()}};
    s_tkeep = $urandom();
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    s_valid = 1'($urandom_range(0, 1));
    s_tready = 1'b1;
    s_tlast = 1'b0;
    for (int d = 0; d < ND; d++) begin
      mode[d] = 0;
      nf[d] = '0;
      ns[d] = '0;
    end
    repeat (n) tick();
    rst = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(int d, int flen, bit gappy, bit no_last);
    int pos, n, nbd;
    logic last;
    nbd = nb_of(d);
    sel = d;
    pos = 0;
    while (pos < flen) begin
      if (gappy && $urandom_range(0, 3) == 0) begin
        idle_cycle();
        continue;
      end
      n = gappy ? $urandom_range(0, nbd) : nbd;
      if (n > flen - pos) n = flen - pos;
      last = !no_last && (pos + n == flen);
      s_tdata = {8{$urandom()}};
      s_tkeep = $urandom();
      for (int i = 0; i < nbd; i++) begin
        if (i < n) begin
          s_tdata[8*i +: 8] = fb[pos+i];
          s_tkeep[i] = 1'b1;
          bb[i] = fb[pos+i];
        end else if (i == n) begin
          s_tkeep[i] = 1'b0;
        end
      end
      s_valid = 1'b1;
      s_tready = 1'b1;
      s_tlast = last;
      model_beat(d, n, last);
      pos += n;
      tick();
    end
    s_valid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic build(int tags, logic [15:0] tp0, logic [15:0] tc0,
                       logic [15:0] tp1, logic [15:0] tc1,
                       logic [15:0] eth);
    int p;
    for (int i = 0; i < 128; i++) fb[i] = 8'($urandom());
    p = 12;
    if (tags >= 1) begin
      {fb[12], fb[13]} = tp0;
      {fb[14], fb[15]} = tc0;
      p = 16;
    end
    if (tags >= 2) begin
      {fb[16], fb[17]} = tp1;
      {fb[18], fb[19]} = tc1;
      p = 20;
    end
    {fb[p], fb[p+1]} = eth;
    {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]} = 48'h020000000001;
  endtask

  function automatic logic [15:0] pick_tp();
    case ($urandom_range(0, 3))
      0: return 16'h8100;
      1: return 16'h88A8;
      2: return 16'h8101;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int c0, v0, e0;
    rst = 1'b1;
    s_valid = 1'b0;
    s_tready = 1'b0;
    s_tlast = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    sel = 0;
    for (int d = 0; d < ND; d++) begin
      mode[d] = 0;
      vcnt[d] = 0;
      ecnt[d] = 0;
      vcyc[d] = 0;
      es[d] = '0;
      ns[d] = '0;
      ef[d] = '0;
      nf[d] = '0;
    end
    do_reset(3);
    chk_en = 1'b1;
    chk("rst hdr_len", 64'(o_len[0]), 64'd0);
    chk("rst busy", 64'(o_b[0]), 64'd0);
    chk("rst dst", 64'(o_dst[2]), 64'd0);

    // Untagged, 3 full 64-bit beats.
    build(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0800);
    c0 = cyc;
    v0 = vcnt[0];
    send_frame(0, 24, 1'b0, 1'b0);
    idle_cycle();
    chk("untag valid cycle", 64'(vcyc[0]), 64'(c0 + 2));
    chk("untag pulses", 64'(vcnt[0] - v0), 64'd1);
    chk("untag len", 64'(o_len[0]), 64'd14);
    chk("untag vc", 64'(o_vc[0]), 64'd0);
    chk("untag eth", 64'(o_eth[0]), 64'h0800);
    chk("untag dst", 64'(o_dst[0]), 64'h020000000001);
    chk("model untag eth", 64'(ef[0].eth), 64'h0800);

    // Single tag.
    build(1, 16'h8100, 16'h0064, 16'h0, 16'h0, 16'h86DD);
    send_frame(0, 40, 1'b1, 1'b0);
    idle_cycle();
    chk("tag1 len", 64'(o_len[0]), 64'd18);
    chk("tag1 vc", 64'(o_vc[0]), 64'd1);
    chk("tag1 otci", 64'(o_ot[0]), 64'h0064);
    chk("tag1 eth", 64'(o_eth[0]), 64'h86DD);
    chk("model tag1 len", 64'(ef[0].len), 64'd18);

    // QinQ on depth 2 and depth 1.
    build(2, 16'h88A8, 16'h0123, 16'h8100, 16'h0456, 16'h0800);
    send_frame(0, 48, 1'b0, 1'b0);
    idle_cycle();
    chk("qinq len", 64'(o_len[0]), 64'd22);
    chk("qinq otci", 64'(o_ot[0]), 64'h0123);
    chk("qinq itci", 64'(o_it[0]), 64'h0456);
    chk("qinq eth", 64'(o_eth[0]), 64'h0800);
    send_frame(3, 48, 1'b0, 1'b0);
    idle_cycle();
    chk("d1 qinq len", 64'(o_len[3]), 64'd18);
    chk("d1 qinq eth", 64'(o_eth[3]), 64'h8100);
    chk("d1 qinq itci", 64'(o_it[3]), 64'h0);
    chk("model d1 eth", 64'(ef[3].eth), 64'h8100);

    // QinQ on 8-bit and 256-bit with gaps and partial keep.
    send_frame(1, 48, 1'b1, 1'b0);
    send_frame(2, 48, 1'b1, 1'b0);
    idle_cycle();
    chk("w8 len", 64'(o_len[1]), 64'd22);
    chk("w8 itci", 64'(o_it[1]), 64'h0456);
    chk("w256 len", 64'(o_len[2]), 64'd22);
    chk("w256 otci", 64'(o_ot[2]), 64'h0123);

    // 10-byte runt.
    build(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0800);
    v0 = vcnt[0];
    e0 = ecnt[0];
    send_frame(0, 10, 1'b0, 1'b0);
    idle_cycle();
    chk("runt err", 64'(ecnt[0] - e0), 64'd1);
    chk("runt no valid", 64'(vcnt[0] - v0), 64'd0);
    chk("runt len held", 64'(o_len[0]), 64'd22);
    chk("runt busy", 64'(o_b[0]), 64'd0);

    // Reset at byte 9, then a clean frame.
    build(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0800);
    v0 = vcnt[0];
    e0 = ecnt[0];
    send_frame(0, 9, 1'b1, 1'b1);
    do_reset(2);
    idle_cycle();
    chk("abort pulses", 64'(vcnt[0] - v0 + ecnt[0] - e0), 64'd0);
    chk("abort len", 64'(o_len[0]), 64'd0);
    build(1, 16'h8100, 16'h0ABC, 16'h0, 16'h0, 16'h0806);
    send_frame(0, 60, 1'b1, 1'b0);
    idle_cycle();
    chk("clean len", 64'(o_len[0]), 64'd18);
    chk("clean otci", 64'(o_ot[0]), 64'h0ABC);
    chk("clean eth", 64'(o_eth[0]), 64'h0806);

    for (int f = 0; f < 300; f++) begin
      int d, fl, tg;
      bit gp;
      d = $urandom_range(0, ND - 1);
      fl = $urandom_range(6, 80);
      tg = $urandom_range(0, 2);
      gp = ($urandom_range(0, 3) != 0);
      build(tg, pick_tp(), 16'($urandom()), pick_tp(),
            16'($urandom()), 16'($urandom()));
      send_frame(d, fl, gp, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
